// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Build option: UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam int   IO_ERR_W         = 5;
  localparam int   IO_ERR_PROTO_BIT = 0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;
`endif

  function automatic logic evenParity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered storage and a combinational head output.
// Pointers carry one extra wrap bit so that full and empty are distinguishable.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_pop,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW:0]               r_wptr;
  logic [AW:0]               r_rptr;
  logic                      w_doPush;
  logic                      w_doPop;

  assign o_count  = r_wptr - r_rptr;
  assign o_full   = (o_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_wptr == r_rptr);
  assign o_data   = r_mem[r_rptr[AW-1:0]];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + 1'b1;
      if (w_doPop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes from the core are queued, then framed LSB first.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between bit 7 and stop.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] in_data,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic                      txd,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count,
  output logic [IO_ERR_W-1:0]       err
);

  localparam int TW = $clog2(CLK_PER_BIT);

  tx_state_e                 r_state;
  logic [TW-1:0]             r_timer;
  logic [2:0]                r_bitIdx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_txd;
  logic                      r_blocked;
  logic                      r_protoErr;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_bitDone;
  logic [UART_DATA_BITS-1:0] w_head;

  assign in_rdy    = ~rst && ~w_full;
  assign w_push    = in_vld && in_rdy;
  assign w_bitDone = (r_timer == TW'(CLK_PER_BIT - 1));
  // The FSM only sees bytes already counted, so a same-edge push into an empty FIFO waits one cycle.
  assign w_pop     = !w_empty && ((r_state == TX_IDLE) || (r_state == TX_STOP && w_bitDone));
  assign busy      = (r_state != TX_IDLE) || !w_empty;
  assign txd       = r_txd;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= TX_IDLE;
      r_timer  <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_txd    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_txd <= UART_IDLE_LEVEL;
          if (w_pop) begin
            r_shift  <= w_head;
            r_txd    <= 1'b0;
            r_timer  <= '0;
            r_state  <= TX_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= evenParity(w_head);
`endif
          end
        end
        TX_START: begin
          if (w_bitDone) begin
            r_timer  <= '0;
            r_bitIdx <= '0;
            r_txd    <= r_shift[0];
            r_state  <= TX_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_bitDone) begin
            r_timer <= '0;
            if (r_bitIdx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_parity;
              r_state <= TX_PARITY;
`else
              r_txd   <= UART_IDLE_LEVEL;
              r_state <= TX_STOP;
`endif
            end else begin
              r_shift  <= r_shift >> 1;
              r_txd    <= r_shift[1];
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (w_bitDone) begin
            r_timer <= '0;
            r_txd   <= UART_IDLE_LEVEL;
            r_state <= TX_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (w_bitDone) begin
            r_timer <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (w_pop) begin
              r_shift  <= w_head;
              r_txd    <= 1'b0;
              r_state  <= TX_START;
`ifdef UART_TX_PARITY_EN
              r_parity <= evenParity(w_head);
`endif
            end else begin
              r_txd   <= UART_IDLE_LEVEL;
              r_state <= TX_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_txd   <= UART_IDLE_LEVEL;
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

  // A byte offered while blocked and then withdrawn without a handshake is a protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blocked  <= 1'b0;
      r_protoErr <= 1'b0;
    end else begin
      r_blocked <= in_vld && !in_rdy;
      if (r_blocked && !in_vld) r_protoErr <= 1'b1;
    end
  end

  always_comb begin
    err                   = '0;
    err[IO_ERR_PROTO_BIT] = r_protoErr;
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: directed and random pushes checked every cycle against a frame-timing model.
// Build option: UART_TX_PARITY_EN switches the model to 11-bit frames with even parity.
module tb_uart_tx_buf;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int F = FBITS * CPB;

  typedef struct {
    int         start;
    logic [7:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic       txd;
  logic       busy;
  logic [2:0] count;
  logic [4:0] err;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     checkEn = 0;
  bit     lastHs = 0;
  frame_t frames[$];
  int     lastEnd = 0;
  bit     errExp = 0;
  bit     prevBlocked = 0;

  uart_tx_buf #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .txd     (txd),
    .busy    (busy),
    .count   (count),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Bytes waiting in the FIFO after edge t are the frames that have not started yet.
  function automatic int modelCount(input int t);
    int n = 0;
    foreach (frames[i]) if (frames[i].start > t) n++;
    return n;
  endfunction

  function automatic bit modelInFrame(input int t);
    foreach (frames[i]) if (t >= frames[i].start && t < frames[i].start + F) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic modelTxd(input int t);
    int b;
    foreach (frames[i]) begin
      if (t >= frames[i].start && t < frames[i].start + F) begin
        b = (t - frames[i].start) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return frames[i].data[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^frames[i].data;
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    int  n;
    logic expRdy;
    n      = modelCount(cyc);
    expRdy = !rst && (n != DEPTH);
    expectEq("txd",    32'(txd),    32'(modelTxd(cyc)));
    expectEq("count",  32'(count),  32'(n));
    expectEq("busy",   32'(busy),   32'(modelInFrame(cyc) || (n != 0)));
    expectEq("in_rdy", 32'(in_rdy), 32'(expRdy));
    expectEq("err",    32'(err),    32'({4'b0000, errExp}));
  endtask

  task automatic applyStimulus(input logic vld, input logic [7:0] d, input logic r);
    in_vld  = vld;
    in_data = d;
    rst     = r;
  endtask

  // Advance one clock: check outputs mid-cycle, then update the model with this edge's inputs.
  task automatic tick();
    logic expRdy;
    bit   hs;
    bit   blk;
    int   s;
    @(negedge clk);
    if (checkEn) checkOutput();
    expRdy = !rst && (modelCount(cyc) != DEPTH);
    hs     = in_vld && expRdy;
    blk    = in_vld && !expRdy;
    @(posedge clk);
    cyc++;
    if (rst) begin
      frames.delete();
      lastEnd     = 0;
      errExp      = 0;
      prevBlocked = 0;
    end else begin
      if (prevBlocked && !in_vld) errExp = 1;
      prevBlocked = blk;
      if (hs) begin
        s = (cyc + 1 > lastEnd) ? cyc + 1 : lastEnd;
        frames.push_back('{start: s, data: in_data});
        lastEnd = s + F;
      end
    end
    lastHs = hs;
    #1;
    checkEn = 1;
  endtask

  task automatic pushHeld(input logic [7:0] d);
    int guard = 0;
    applyStimulus(1'b1, d, 1'b0);
    tick();
    while (!lastHs && guard < 400) begin
      tick();
      guard++;
    end
    expectEq("push_accepted", 32'(lastHs), 32'd1);
  endtask

  task automatic waitDrain();
    int guard = 0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    while (cyc < lastEnd + 2 && guard < 3000) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (3) tick();
    expectEq("rst_rdy",   32'(in_rdy), 32'd0);
    expectEq("rst_txd",   32'(txd),    32'd1);
    expectEq("rst_count", 32'(count),  32'd0);
    expectEq("rst_busy",  32'(busy),   32'd0);
    expectEq("rst_err",   32'(err),    32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();

    // Single 0x55 frame: start bit appears one edge after the push.
    pushHeld(8'h55);
    applyStimulus(1'b0, 8'h00, 1'b0);
    expectEq("pre_start_txd", 32'(txd), 32'd1);
    tick();
    expectEq("start_bit", 32'(txd), 32'd0);
    waitDrain();
    expectEq("busy_fall", 32'(busy), 32'd0);

    // Two consecutive pushes produce contiguous frames.
    pushHeld(8'hA3);
    pushHeld(8'h0F);
    waitDrain();

    // Continuous pushing fills the FIFO; the sixth byte must wait.
    for (int n = 0; n < 8; n++) begin
      if (n == 5) begin
        expectEq("full_count", 32'(count),  32'd4);
        expectEq("full_rdy",   32'(in_rdy), 32'd0);
      end
      pushHeld(8'($urandom));
    end
    waitDrain();

    // Reset in the middle of a 0xFF frame with three bytes queued.
    pushHeld(8'hFF);
    pushHeld(8'h12);
    pushHeld(8'h34);
    pushHeld(8'h56);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (8) tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    expectEq("midrst_txd",   32'(txd),   32'd1);
    expectEq("midrst_count", 32'(count), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (60) tick();
    expectEq("postrst_busy", 32'(busy), 32'd0);
    expectEq("postrst_txd",  32'(txd),  32'd1);

    // Offer a byte while full, then withdraw it: sticky protocol error.
    for (int n = 0; n < 5; n++) pushHeld(8'(8'h60 + n));
    applyStimulus(1'b1, 8'hEE, 1'b0);
    expectEq("err_full_rdy", 32'(in_rdy), 32'd0);
    tick();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    expectEq("err_set", 32'(err), 32'd1);
    waitDrain();
    expectEq("err_sticky", 32'(err), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    expectEq("err_cleared", 32'(err), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();

    // Random bytes with random gaps, including back-to-back bursts.
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 45);
      applyStimulus(1'b0, 8'h00, 1'b0);
      repeat (gap) tick();
      pushHeld(8'($urandom));
    end
    waitDrain();
    expectEq("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
